// File: rtl/aes128_dec_core.sv
// aes128_dec_core: iterative AES-128 inverse cipher, one round per clock.
// The final round key is derived by running the forward key expansion, then
// the schedule is walked backwards in step with the rounds (no key storage).
// Optional build macro AES_DEC_KEYCACHE_EN: remembers the last cipher key and
// its final round key so a repeated key skips the forward expansion.
module aes128_dec_core #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key,
   input  logic [127:0] ct,
   output logic [127:0] pt,
   output logic         busy,
   output logic         done
);

   // Handshake: start is a level request accepted only in IDLE or DONE (ignored
   // otherwise, never queued); done is a level that holds with pt stable until
   // the next accepted start or reset; busy covers every working state.

   generate
      if (NR != 10) begin : g_nr_check
         $error("aes128_dec_core: NR must be 10 for AES-128");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, KEYEXP, INIT_ADDKEY, ROUND, DONE} state_t;

   state_t       state, state_nxt;
   logic [127:0] rk, st;
   logic [3:0]   rc;
   logic [127:0] round_out, rk_fwd, rk_bwd, rk_load;
   logic [3:0]   rk_bwd_rc;
   logic         cache_hit;
   logic         accept;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8); maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq, r;
      sq = a;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] a;
      a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
      return gf_inv(a);
   endfunction

   function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc8);
      logic [31:0] n0, n1, n2, n3;
      n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc8, 24'h0};
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc8);
      logic [31:0] n0, n1, n2, n3;
      n3 = k[31:0] ^ k[63:32];
      n2 = k[63:32] ^ k[95:64];
      n1 = k[95:64] ^ k[127:96];
      n0 = k[127:96] ^ sub_rot_word(n3) ^ {rc8, 24'h0};
      return {n0, n1, n2, n3};
   endfunction

   // InvShiftRows, InvSubBytes, AddRoundKey, then optional InvMixColumns.
   function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic mix);
      logic [127:0] t, o;
      logic [7:0]   a0, a1, a2, a3;
      int           src;
      for (int i = 0; i < 16; i++) begin
         src = 4 * (((i / 4) - (i % 4) + 4) % 4) + (i % 4);
         t[127-8*i -: 8] = inv_sbox(s[127-8*src -: 8]) ^ k[127-8*i -: 8];
      end
      o = t;
      if (mix) begin
         for (int c = 0; c < 4; c++) begin
            a0 = t[127-32*c -: 8];
            a1 = t[119-32*c -: 8];
            a2 = t[111-32*c -: 8];
            a3 = t[103-32*c -: 8];
            o[127-32*c -: 32] = {
               gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
               gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
               gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
               gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
         end
      end
      return o;
   endfunction

   assign accept    = ((state == IDLE) || (state == DONE)) && start;
   assign rk_fwd    = key_fwd(rk, rcon(rc));
   assign rk_bwd_rc = (state == INIT_ADDKEY) ? 4'(NR) : rc;
   assign rk_bwd    = key_inv(rk, rcon(rk_bwd_rc));
   assign round_out = inv_round(st, rk, rc != 4'd0);
   assign busy      = (state == KEYEXP) || (state == INIT_ADDKEY) || (state == ROUND);
   assign done      = (state == DONE);

`ifdef AES_DEC_KEYCACHE_EN
   logic [127:0] tag, cache_rk;
   logic         tag_valid;

   assign cache_hit = tag_valid && (key == tag);
   assign rk_load   = cache_hit ? cache_rk : key;

   // Remember the key on a miss; mark it valid once its final round key exists.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag       <= '0;
         cache_rk  <= '0;
         tag_valid <= 1'b0;
      end else if (accept && !cache_hit) begin
         tag       <= key;
         tag_valid <= 1'b0;
      end else if ((state == KEYEXP) && (rc == 4'(NR))) begin
         cache_rk  <= rk_fwd;
         tag_valid <= 1'b1;
      end
   end
`else
   assign cache_hit = 1'b0;
   assign rk_load   = key;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE:  if (start) state_nxt = cache_hit ? INIT_ADDKEY : KEYEXP;
         KEYEXP:      if (rc == 4'(NR)) state_nxt = INIT_ADDKEY;
         INIT_ADDKEY: state_nxt = ROUND;
         ROUND:       if (rc == 4'd0) state_nxt = DONE;
         default:     state_nxt = IDLE;
      endcase
   end

   // Datapath: key walk, cipher state, round counter and result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rk <= '0;
         st <= '0;
         rc <= '0;
         pt <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  rk <= rk_load;
                  st <= ct;
                  rc <= 4'd1;
               end
            end
            KEYEXP: begin
               rk <= rk_fwd;
               rc <= rc + 4'd1;
            end
            INIT_ADDKEY: begin
               st <= st ^ rk;
               rk <= rk_bwd;
               rc <= 4'(NR - 1);
            end
            ROUND: begin
               st <= round_out;
               rk <= rk_bwd;
               rc <= rc - 4'd1;
               if (rc == 4'd0) pt <= round_out;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_dec_core.sv
// tb_aes128_dec_core: directed and round-trip checks for aes128_dec_core.
// Builds with or without AES_DEC_KEYCACHE_EN; repeated-key latency follows it.
module tb_aes128_dec_core;

   localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_C1   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] RK10_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam int           LAT_FULL = 21;
`ifdef AES_DEC_KEYCACHE_EN
   localparam int           LAT_HIT  = 11;
`else
   localparam int           LAT_HIT  = 21;
`endif

   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
      bit           same_key;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [127:0] key = '0;
   logic [127:0] ct = '0;
   logic [127:0] pt;
   logic         busy;
   logic         done;

   int           n_pass = 0;
   int           n_total = 0;
   logic [127:0] exp_q[$];
   logic [7:0]   sbox_t[256];
   vec_t         vecs[6];

   aes128_dec_core #(.NR(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .key(key), .ct(ct),
      .pt(pt), .busy(busy), .done(done)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got no summary, required completion before timeout");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d required %0d", name, act, exp);
   endtask

   // ---------------- reference encryptor for round trips ----------------
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b0};
         q = q ^ {q[3:0], 4'b0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox_t[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox_t[0] = 8'h63;
   endtask

   function automatic logic [7:0] x2(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
      logic [127:0] s, w, t;
      logic [31:0]  tw;
      logic [7:0]   rc8, b0, b1, b2, b3;
      int           src;
      rc8 = 8'h01;
      w   = k;
      s   = p ^ k;
      for (int r = 1; r <= 10; r++) begin
         tw = {sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]], sbox_t[w[31:24]]} ^ {rc8, 24'h0};
         w[127:96] = w[127:96] ^ tw;
         w[95:64]  = w[95:64] ^ w[127:96];
         w[63:32]  = w[63:32] ^ w[95:64];
         w[31:0]   = w[31:0] ^ w[63:32];
         rc8 = x2(rc8);
         for (int i = 0; i < 16; i++) begin
            src = 4 * (((i / 4) + (i % 4)) % 4) + (i % 4);
            t[127-8*i -: 8] = sbox_t[s[127-8*src -: 8]];
         end
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               b0 = t[127-32*c -: 8];
               b1 = t[119-32*c -: 8];
               b2 = t[111-32*c -: 8];
               b3 = t[103-32*c -: 8];
               t[127-32*c -: 32] = {x2(b0) ^ x2(b1) ^ b1 ^ b2 ^ b3,
                                    b0 ^ x2(b1) ^ x2(b2) ^ b2 ^ b3,
                                    b0 ^ b1 ^ x2(b2) ^ x2(b3) ^ b3,
                                    x2(b0) ^ b0 ^ b1 ^ b2 ^ x2(b3)};
            end
         end
         s = t ^ w;
      end
      return s;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Pulse start for one edge, then count edges until done (bounded).
   task automatic run_op(input logic [127:0] k, input logic [127:0] c,
                         output int lat, output logic [127:0] res);
      @(negedge clk);
      key   = k;
      ct    = c;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = 0;
      while (!done && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
      res = pt;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int           lat, first_d, second_d, n_done, hold_err;
      logic [127:0] res, k, p, c;

      build_sbox();
      vecs[0] = '{KEY_C1, CT_C1, PT_C1, 1'b0};
      vecs[1] = '{KEY_B, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h6bc1bee22e409f96e93d7e117393172a, 1'b0};
      vecs[2] = '{KEY_B, 128'hf5d3d58503b9699de785895a96fdbaaf, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b1};
      vecs[3] = '{KEY_B, 128'h43b1cd7f598ece23881b00e3ed030688, 128'h30c81c46a35ce411e5fbc1191a0a52ef, 1'b1};
      vecs[4] = '{KEY_B, 128'h7b0c785e27e8ad3f8223207104725dd4, 128'hf69f2445df4f9b17ad2b417be66c3710, 1'b1};
      vecs[5] = '{KEY_B, CT_B, PT_B, 1'b1};

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_pt", pt, '0);
      check_int("rst_busy", int'(busy), 0);
      check_int("rst_done", int'(done), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_int("idle_done", int'(done), 0);

      // FIPS-197 B with a look at the derived final round key.
      @(negedge clk);
      key = KEY_B; ct = CT_B; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check_int("busy_after_start", int'(busy), 1);
      repeat (10) @(posedge clk);
      #1;
      check("rk10_after_keyexp", dut.rk, RK10_B);
      lat = 10;
      while (!done && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_int("fips_b_lat", lat, LAT_FULL);
      check("fips_b_pt", pt, PT_B);

      // Vector table, back-to-back from DONE.
      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].key, vecs[i].ct, lat, res);
         check($sformatf("vec%0d_pt", i), res, vecs[i].pt);
         check_int($sformatf("vec%0d_lat", i), lat, vecs[i].same_key ? LAT_HIT : LAT_FULL);
      end

      // Stray start pulses at cycles 3, 10, 15 are ignored; pt holds until done.
      @(negedge clk);
      key = KEY_C1; ct = CT_C1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      first_d = -1; n_done = 0; hold_err = 0;
      for (int cyc = 1; cyc <= 25; cyc++) begin
         if (cyc == 3 || cyc == 10 || cyc == 15) begin
            key = KEY_B; ct = CT_B; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         if (done) begin
            n_done++;
            if (first_d < 0) first_d = cyc;
         end else if (pt !== PT_B) begin
            hold_err++;
         end
      end
      start = 1'b0;
      check_int("ignore_first_done", first_d, LAT_FULL);
      check_int("ignore_done_cycles", n_done, 25 - LAT_FULL + 1);
      check_int("ignore_pt_hold_errors", hold_err, 0);
      check("ignore_pt", pt, PT_C1);

      // Asynchronous reset in the middle of an operation.
      @(negedge clk);
      key = KEY_B; ct = CT_B; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_pt", pt, '0);
      check_int("midrst_done", int'(done), 0);
      check_int("midrst_busy", int'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(KEY_C1, CT_C1, lat, res);
      check_int("after_rst_lat", lat, LAT_FULL);
      check("after_rst_pt", res, PT_C1);

      // start held high: DONE lasts one cycle, then the next operation runs.
      @(negedge clk);
      key = KEY_C1; ct = CT_C1; start = 1'b1;
      first_d = -1; second_d = -1; n_done = 0;
      for (int cyc = 0; cyc <= 2 * LAT_HIT + 1; cyc++) begin
         @(posedge clk);
         #1;
         if (done) begin
            n_done++;
            if (first_d < 0) first_d = cyc;
            else second_d = cyc;
         end
      end
      start = 1'b0;
      check_int("held_first_done", first_d, LAT_HIT);
      check_int("held_second_done", second_d, 2 * LAT_HIT + 1);
      check_int("held_done_cycles", n_done, 2);
      check("held_pt", pt, PT_C1);

`ifdef AES_DEC_KEYCACHE_EN
      // Key cache: miss on a new key, cleared by reset, hit on repeat.
      run_op(KEY_B, CT_B, lat, res);
      check_int("cache_b_lat", lat, LAT_FULL);
      check("cache_b_pt", res, PT_B);
      do_reset();
      run_op(KEY_C1, CT_C1, lat, res);
      check_int("cache_rst_lat", lat, LAT_FULL);
      check("cache_rst_pt", res, PT_C1);
      run_op(KEY_C1, CT_C1, lat, res);
      check_int("cache_hit_lat", lat, LAT_HIT);
      check("cache_hit_pt", res, PT_C1);
`endif

      // Round trips through the reference encryptor.
      do_reset();
      for (int i = 0; i < 100; i++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         p = {$urandom, $urandom, $urandom, $urandom};
         c = aes_enc(k, p);
         exp_q.push_back(p);
         run_op(k, c, lat, res);
         check_int($sformatf("rt%0d_lat", i), lat, LAT_FULL);
         check($sformatf("rt%0d_pt", i), res, exp_q.pop_front());
      end

      // ---------------- final report ----------------
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
